// File: rtl/mor1kx_sb_pkg.sv
// Shared definitions for the store-buffer drain: FSM state width and encodings.
package mor1kx_sb_pkg;

  localparam int SB_STATE_W = 2;

  typedef enum logic [SB_STATE_W-1:0] {
    SB_IDLE    = 2'd0,
    SB_CAPTURE = 2'd1,
    SB_BUS     = 2'd2,
    SB_ERROR   = 2'd3
  } sb_state_e;

endpackage

// File: rtl/mor1kx_sb_drain.sv
// Store-buffer drain: pops buffered stores and writes them to the data bus one at a time.
// Optional load-address snoop against the in-flight store: define MOR1KX_SB_DRAIN_SNOOP_EN.
module mor1kx_sb_drain
  import mor1kx_sb_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sb_empty_i,
  output logic                              sb_read_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
  input  logic                              sb_atomic_i,
  input  logic                              atomic_reserve_i,
  output logic                              dbus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
  input  logic                              dbus_ack_i,
  input  logic                              dbus_err_i,
  output logic                              atomic_done_o,
  output logic                              atomic_ok_o,
  output logic                              err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_adr_o,
  input  logic                              err_clr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   snoop_adr_i,
  output logic                              snoop_hit_o,
  output logic                              busy_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int BW = OPTION_OPERAND_WIDTH / 8;

  sb_state_e       state_q, state_d;
  logic [W-1:0]    adr_q, dat_q, pc_q, err_pc_q, err_adr_q;
  logic [BW-1:0]   bsel_q;
  logic            atomic_q, req_q, done_q, ok_q, err_q;

  logic bus_ack, bus_err, atomic_fail;

  // A bus error wins over an ack arriving in the same cycle.
  assign bus_err     = (state_q == SB_BUS) && dbus_err_i;
  assign bus_ack     = (state_q == SB_BUS) && dbus_ack_i && !dbus_err_i;
  assign atomic_fail = (state_q == SB_CAPTURE) && sb_atomic_i && !atomic_reserve_i;

  // The next pop overlaps the ack cycle so back-to-back stores lose no extra cycle.
  assign sb_read_o = !rst && !sb_empty_i && ((state_q == SB_IDLE) || bus_ack);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE:    if (!sb_empty_i) state_d = SB_CAPTURE;
      SB_CAPTURE: state_d = atomic_fail ? SB_IDLE : SB_BUS;
      SB_BUS: begin
        if (dbus_err_i)      state_d = SB_ERROR;
        else if (dbus_ack_i) state_d = sb_empty_i ? SB_IDLE : SB_CAPTURE;
      end
      SB_ERROR:   if (err_clr_i) state_d = SB_IDLE;
      default:    state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SB_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      pc_q      <= '0;
      bsel_q    <= '0;
      atomic_q  <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_pc_q  <= '0;
      err_adr_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      if (state_q == SB_CAPTURE) begin
        adr_q    <= sb_adr_i;
        dat_q    <= sb_dat_i;
        pc_q     <= sb_pc_i;
        bsel_q   <= sb_bsel_i;
        atomic_q <= sb_atomic_i;
        req_q    <= !atomic_fail;
        done_q   <= atomic_fail;
      end
      if (bus_err) begin
        req_q     <= 1'b0;
        err_q     <= 1'b0 | 1'b1;
        err_pc_q  <= pc_q;
        err_adr_q <= adr_q;
        done_q    <= atomic_q;
      end else if (bus_ack) begin
        req_q  <= 1'b0;
        done_q <= atomic_q;
        ok_q   <= atomic_q;
      end
      if ((state_q == SB_ERROR) && err_clr_i) err_q <= 1'b0;
    end
  end

  assign dbus_req_o    = req_q;
  assign dbus_adr_o    = adr_q;
  assign dbus_dat_o    = dat_q;
  assign dbus_bsel_o   = bsel_q;
  assign atomic_done_o = done_q;
  assign atomic_ok_o   = ok_q;
  assign err_o         = err_q;
  assign err_pc_o      = err_pc_q;
  assign err_adr_o     = err_adr_q;
  assign busy_o        = (state_q != SB_IDLE) || !sb_empty_i;

  // Snoop matches on the word address of the store currently on the bus.
`ifdef MOR1KX_SB_DRAIN_SNOOP_EN
  logic snoop_unused;
  assign snoop_unused = ^snoop_adr_i[1:0];
  assign snoop_hit_o  = !rst && (state_q == SB_BUS) && (snoop_adr_i[W-1:2] == adr_q[W-1:2]);
`else
  logic snoop_unused;
  assign snoop_unused = ^snoop_adr_i;
  assign snoop_hit_o  = 1'b0;
`endif

endmodule
